// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised asynchronous serial receiver.
// The line is synchronised, then sampled at mid-bit with false-start rejection.
// Each received word carries parity and framing status, and is handed to a
// same-domain consumer over a valid/ready handshake with overrun reporting.
module uart_rx_param #(
   parameter int CLKS_PER_BIT = 16,
   parameter int DATA_BITS    = 8,
   parameter int PARITY       = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] data,
   output logic                 valid,
   input  logic                 out_ready,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic                 overrun,
   output logic                 busy
);

   localparam int HALF = CLKS_PER_BIT / 2;
   localparam int CW   = $clog2(CLKS_PER_BIT + 1);
   localparam int BW   = 4;

   localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
   localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
   // Odd parity expects an odd count of ones over data plus parity bit.
   localparam logic          PAR_INV   = (PARITY == 2) ? 1'b0 : 1'b1;

   typedef enum logic [2:0] {
      WAIT_HIGH,
      IDLE,
      START,
      DATA,
      PAR,
      STOP
   } state_t;

   state_t               state;
   state_t               state_nxt;

   logic                 rx_meta;
   logic                 rx_s;
   logic [1:0]           sync_fill;
   logic                 sync_ok;

   logic [CW-1:0]        clk_cnt;
   logic [BW-1:0]        bit_cnt;
   logic [DATA_BITS-1:0] shift;
   logic                 par_bit_q;
   logic                 stop_err_q;

   logic                 sample;
   logic                 last_bit;
   logic                 frame_done;
   logic                 frame_perr;
   logic                 frame_ferr;
   logic                 load;

   // Two-flop synchroniser on rx, plus a tracker of when rx_s holds a real sample.
   // NOTE: sequential state uses <= so every flop sees pre-edge values,
   // independent of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         rx_meta   <= 1'b1;
         rx_s      <= 1'b1;
         sync_fill <= 2'b00;
      end else begin
         rx_meta   <= rx;
         rx_s      <= rx_meta;
         sync_fill <= {sync_fill[0], 1'b1};
      end
   end

   // The synchroniser resets to 1, which would look like an idle line to
   // WAIT_HIGH; only trust rx_s once it carries a value sampled after reset.
   assign sync_ok = sync_fill[1];

   // FSM state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= WAIT_HIGH;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic.
   // NOTE: every variable written in always_comb gets a default first, so no
   // path can leave it unassigned and infer a latch.
   always_comb begin
      state_nxt = state;
      case (state)
         WAIT_HIGH: if (sync_ok && rx_s) state_nxt = IDLE;
         IDLE:      if (!rx_s) state_nxt = START;
         START: begin
            if (sample) state_nxt = rx_s ? IDLE : DATA;
         end
         DATA: begin
            if (sample && last_bit) state_nxt = (PARITY != 0) ? PAR : STOP;
         end
         PAR: begin
            if (sample) state_nxt = STOP;
         end
         STOP: begin
            // A low final stop bit may be a break; wait for the line to idle.
            if (frame_done) state_nxt = rx_s ? IDLE : WAIT_HIGH;
         end
         default: state_nxt = WAIT_HIGH;
      endcase
   end

   // FSM outputs: busy flag, sample strobes and end-of-frame detection.
   always_comb begin
      busy     = 1'b0;
      sample   = 1'b0;
      last_bit = 1'b0;
      case (state)
         START: begin
            busy   = 1'b1;
            sample = (clk_cnt == HALF_LAST);
         end
         DATA: begin
            busy     = 1'b1;
            sample   = (clk_cnt == BIT_LAST);
            last_bit = (bit_cnt == DATA_LAST);
         end
         PAR: begin
            busy   = 1'b1;
            sample = (clk_cnt == BIT_LAST);
         end
         STOP: begin
            busy     = 1'b1;
            sample   = (clk_cnt == BIT_LAST);
            last_bit = (bit_cnt == STOP_LAST);
         end
         default: begin
            busy   = 1'b0;
            sample = 1'b0;
         end
      endcase
      frame_done = (state == STOP) && sample && last_bit;
   end

   // Clock counter: restarts at each sample point, held at zero while not busy.
   always_ff @(posedge clk) begin
      if (reset) begin
         clk_cnt <= '0;
      end else if (busy && !sample) begin
         clk_cnt <= clk_cnt + CW'(1);
      end else begin
         clk_cnt <= '0;
      end
   end

   // Bit counter: counts data bits, then stop bits, within the current frame.
   always_ff @(posedge clk) begin
      if (reset) begin
         bit_cnt <= '0;
      end else if (sample && (state == DATA || state == STOP)) begin
         bit_cnt <= last_bit ? '0 : bit_cnt + BW'(1);
      end else if (!busy) begin
         bit_cnt <= '0;
      end
   end

   // Frame capture: data shifted in LSB first, parity bit and early stop errors.
   always_ff @(posedge clk) begin
      if (reset) begin
         shift      <= '0;
         par_bit_q  <= 1'b0;
         stop_err_q <= 1'b0;
      end else begin
         if (sample && state == DATA) begin
            shift <= {rx_s, shift[DATA_BITS-1:1]};
         end
         if (sample && state == PAR) begin
            par_bit_q <= rx_s;
         end
         if (state == START) begin
            stop_err_q <= 1'b0;
         end else if (sample && state == STOP) begin
            stop_err_q <= stop_err_q | ~rx_s;
         end
      end
   end

   // Status of the frame completing this cycle; the final stop sample is live.
   assign frame_ferr = stop_err_q | ~rx_s;
   assign frame_perr = (PARITY != 0) ? ((^shift) ^ par_bit_q ^ PAR_INV) : 1'b0;

   // A completing frame is accepted if the slot is empty or being drained now.
   assign load = frame_done && (!valid || out_ready);

   // Output register and handshake.
   always_ff @(posedge clk) begin
      if (reset) begin
         data       <= '0;
         valid      <= 1'b0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
         overrun    <= 1'b0;
      end else if (load) begin
         data       <= shift;
         valid      <= 1'b1;
         parity_err <= frame_perr;
         frame_err  <= frame_ferr;
         overrun    <= 1'b0;
      end else if (frame_done) begin
         // Held word not yet taken: drop the new frame, keep the old one.
         overrun <= 1'b1;
      end else if (valid && out_ready) begin
         valid      <= 1'b0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
         overrun    <= 1'b0;
      end
   end

endmodule

// File: tb/tb_uart_rx_param.sv
// Self-checking bench for uart_rx_param: a table of frames for the main
// receive path plus directed sequences for break, glitch, overrun and reset.
module tb_uart_rx_param;

   localparam int CPB  = 4;
   localparam int HALF = CPB / 2;
   // Edges from driving the start bit to valid rising (2 sync + HALF + N bits + 1).
   localparam int LAT8 = 2 + HALF + 10 * CPB + 1;
   localparam int LAT7 = 2 + HALF + 9 * CPB + 1;
   localparam int NV   = 8;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       rx = 1'b1;
   logic       rx2 = 1'b1;
   logic       out_ready = 1'b1;

   logic [7:0] data;
   logic       valid, parity_err, frame_err, overrun, busy;
   logic [6:0] data2;
   logic       valid2, perr2, ferr2, ovr2, busy2;

   always #5 clk = ~clk;

   uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) dut (
      .clk(clk), .reset(reset), .rx(rx), .data(data), .valid(valid),
      .out_ready(out_ready), .parity_err(parity_err), .frame_err(frame_err),
      .overrun(overrun), .busy(busy)
   );

   uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) dut2 (
      .clk(clk), .reset(reset), .rx(rx2), .data(data2), .valid(valid2),
      .out_ready(out_ready), .parity_err(perr2), .frame_err(ferr2),
      .overrun(ovr2), .busy(busy2)
   );

   int tests = 0;
   int fails = 0;
   int cyc = 0;

   always @(posedge clk) cyc++;

   // Output monitor, sampled on the falling edge.
   int         vcnt = 0, vcnt2 = 0, bcnt = 0;
   int         rise_cyc = -1, rise_cyc2 = -1;
   logic       prev_valid = 1'b0, prev_valid2 = 1'b0;
   logic [7:0] cap_data = '0;
   logic       cap_pe = 1'b0, cap_fe = 1'b0;
   logic [6:0] cap_data2 = '0;
   logic       cap_pe2 = 1'b0, cap_fe2 = 1'b0;

   always @(negedge clk) begin
      if (valid) begin
         vcnt++;
         cap_data = data;
         cap_pe   = parity_err;
         cap_fe   = frame_err;
         if (!prev_valid) rise_cyc = cyc;
      end
      prev_valid = valid;
      if (busy) bcnt++;
      if (valid2) begin
         vcnt2++;
         cap_data2 = data2;
         cap_pe2   = perr2;
         cap_fe2   = ferr2;
         if (!prev_valid2) rise_cyc2 = cyc;
      end
      prev_valid2 = valid2;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Hold one line level for n clock edges; returns 1 time unit after an edge.
   task automatic drive_bit(input int sel, input logic b, input int n);
      if (sel == 0) rx = b;
      else rx2 = b;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input int sel, input logic [8:0] d, input int nd,
                             input logic has_par, input logic par,
                             input logic [1:0] stop, input int ns);
      drive_bit(sel, 1'b0, CPB);
      for (int i = 0; i < nd; i++) drive_bit(sel, d[i], CPB);
      if (has_par) drive_bit(sel, par, CPB);
      for (int i = 0; i < ns; i++) drive_bit(sel, stop[i], CPB);
   endtask

   typedef struct {
      logic [7:0] d;
      logic       par;
      logic       stop;
      logic       exp_pe;
      logic       exp_fe;
   } vec_t;

   vec_t vecs[NV];

   initial begin
      // Even parity: the correct parity bit equals the XOR of the data bits.
      vecs[0] = '{d: 8'hD5, par: 1'b1, stop: 1'b1, exp_pe: 1'b0, exp_fe: 1'b0};
      vecs[1] = '{d: 8'h33, par: 1'b1, stop: 1'b1, exp_pe: 1'b1, exp_fe: 1'b0};
      vecs[2] = '{d: 8'h33, par: 1'b0, stop: 1'b1, exp_pe: 1'b0, exp_fe: 1'b0};
      vecs[3] = '{d: 8'h00, par: 1'b0, stop: 1'b1, exp_pe: 1'b0, exp_fe: 1'b0};
      vecs[4] = '{d: 8'hFF, par: 1'b0, stop: 1'b1, exp_pe: 1'b0, exp_fe: 1'b0};
      vecs[5] = '{d: 8'h80, par: 1'b0, stop: 1'b1, exp_pe: 1'b1, exp_fe: 1'b0};
      vecs[6] = '{d: 8'h01, par: 1'b1, stop: 1'b1, exp_pe: 1'b0, exp_fe: 1'b0};
      vecs[7] = '{d: 8'hC3, par: 1'b0, stop: 1'b0, exp_pe: 1'b0, exp_fe: 1'b1};
   end

   initial begin
      int v0, v1, b0, t0;

      // Reset state, checked while reset is still asserted.
      drive_bit(0, 1'b1, 3);
      check("reset data", 32'(data), 32'h0);
      check("reset valid", 32'(valid), 32'h0);
      check("reset flags", 32'({parity_err, frame_err, overrun}), 32'h0);
      check("reset busy", 32'(busy), 32'h0);
      reset = 1'b0;
      drive_bit(0, 1'b1, 2 * CPB);

      // Table-driven frames with out_ready held high.
      for (int i = 0; i < NV; i++) begin
         v0 = vcnt;
         t0 = cyc;
         rise_cyc = -1;
         send_frame(0, {1'b0, vecs[i].d}, 8, 1'b1, vecs[i].par, {1'b1, vecs[i].stop}, 1);
         drive_bit(0, 1'b1, 3 * CPB);
         check($sformatf("vec%0d data", i), 32'(cap_data), 32'(vecs[i].d));
         check($sformatf("vec%0d parity_err", i), 32'(cap_pe), 32'(vecs[i].exp_pe));
         check($sformatf("vec%0d frame_err", i), 32'(cap_fe), 32'(vecs[i].exp_fe));
         check($sformatf("vec%0d valid cycles", i), 32'(vcnt - v0), 32'd1);
         check($sformatf("vec%0d latency", i), 32'(rise_cyc - t0), 32'(LAT8));
      end

      // Frame with low stop bit, then line held low for 3 bit times (break).
      v0 = vcnt;
      send_frame(0, 9'h0A5, 8, 1'b1, 1'b0, 2'b00, 1);
      drive_bit(0, 1'b0, 6);
      check("break data", 32'(cap_data), 32'hA5);
      check("break frame_err", 32'(cap_fe), 32'h1);
      check("break parity_err", 32'(cap_pe), 32'h0);
      b0 = bcnt;
      v1 = vcnt;
      drive_bit(0, 1'b0, 3 * CPB - 6);
      check("break busy cycles", 32'(bcnt - b0), 32'h0);
      check("break no frame", 32'(vcnt - v1), 32'h0);
      check("break total frames", 32'(vcnt - v0), 32'h1);
      drive_bit(0, 1'b1, 2 * CPB);
      v0 = vcnt;
      send_frame(0, 9'h00F, 8, 1'b1, 1'b0, 2'b01, 1);
      drive_bit(0, 1'b1, 3 * CPB);
      check("after break data", 32'(cap_data), 32'h0F);
      check("after break flags", 32'({cap_pe, cap_fe}), 32'h0);
      check("after break frames", 32'(vcnt - v0), 32'h1);

      // One-clock glitch on an idle line.
      v0 = vcnt;
      b0 = bcnt;
      drive_bit(0, 1'b0, 1);
      drive_bit(0, 1'b1, 3 * CPB);
      check("glitch busy cycles", 32'(bcnt - b0), 32'(HALF));
      check("glitch no frame", 32'(vcnt - v0), 32'h0);
      check("glitch flags", 32'({parity_err, frame_err, overrun}), 32'h0);

      // Overrun: consumer stalled across two frames.
      out_ready = 1'b0;
      send_frame(0, 9'h011, 8, 1'b1, 1'b0, 2'b01, 1);
      drive_bit(0, 1'b1, 2 * CPB);
      send_frame(0, 9'h022, 8, 1'b1, 1'b0, 2'b01, 1);
      drive_bit(0, 1'b1, 2 * CPB);
      check("overrun held data", 32'(data), 32'h11);
      check("overrun valid", 32'(valid), 32'h1);
      check("overrun flag", 32'(overrun), 32'h1);
      out_ready = 1'b1;
      drive_bit(0, 1'b1, 1);
      out_ready = 1'b0;
      check("drain valid", 32'(valid), 32'h0);
      check("drain overrun", 32'(overrun), 32'h0);

      // Handshake on the exact completion cycle of the second frame.
      send_frame(0, 9'h011, 8, 1'b1, 1'b0, 2'b01, 1);
      drive_bit(0, 1'b1, 2 * CPB);
      check("pre-swap data", 32'(data), 32'h11);
      t0 = cyc;
      fork
         send_frame(0, 9'h022, 8, 1'b1, 1'b0, 2'b01, 1);
         begin
            repeat (LAT8 - 1) @(posedge clk);
            #1 out_ready = 1'b1;
            @(posedge clk);
            #1 out_ready = 1'b0;
         end
      join
      check("swap data", 32'(data), 32'h22);
      check("swap valid", 32'(valid), 32'h1);
      check("swap overrun", 32'(overrun), 32'h0);
      drive_bit(0, 1'b1, CPB);
      check("stall stable data", 32'(data), 32'h22);
      check("stall stable valid", 32'(valid), 32'h1);
      out_ready = 1'b1;
      drive_bit(0, 1'b1, 2);
      check("swap drained", 32'(valid), 32'h0);

      // Reset mid-frame with the line held low.
      v0 = vcnt;
      drive_bit(0, 1'b0, 4 * CPB);
      check("mid-frame busy", 32'(busy), 32'h1);
      reset = 1'b1;
      drive_bit(0, 1'b0, 2);
      reset = 1'b0;
      check("mid reset outputs", 32'({data, valid, parity_err, frame_err, overrun, busy}), 32'h0);
      b0 = bcnt;
      drive_bit(0, 1'b0, 6 * CPB);
      check("low after reset busy", 32'(bcnt - b0), 32'h0);
      check("low after reset frames", 32'(vcnt - v0), 32'h0);
      drive_bit(0, 1'b1, 2 * CPB);
      t0 = cyc;
      rise_cyc = -1;
      send_frame(0, 9'h05A, 8, 1'b1, 1'b0, 2'b01, 1);
      drive_bit(0, 1'b1, 3 * CPB);
      check("post reset data", 32'(cap_data), 32'h5A);
      check("post reset flags", 32'({cap_pe, cap_fe}), 32'h0);
      check("post reset latency", 32'(rise_cyc - t0), 32'(LAT8));

      // Second instance: 7 data bits, no parity, 2 stop bits.
      v0 = vcnt2;
      t0 = cyc;
      rise_cyc2 = -1;
      send_frame(1, 9'h07F, 7, 1'b0, 1'b0, 2'b01, 2);
      drive_bit(1, 1'b1, 3 * CPB);
      check("inst2 data", 32'(cap_data2), 32'h7F);
      check("inst2 frame_err", 32'(cap_fe2), 32'h1);
      check("inst2 parity_err", 32'(cap_pe2), 32'h0);
      check("inst2 frames", 32'(vcnt2 - v0), 32'h1);
      check("inst2 latency", 32'(rise_cyc2 - t0), 32'(LAT7));
      send_frame(1, 9'h02A, 7, 1'b0, 1'b0, 2'b11, 2);
      drive_bit(1, 1'b1, 3 * CPB);
      check("inst2 clean data", 32'(cap_data2), 32'h2A);
      check("inst2 clean flags", 32'({cap_pe2, cap_fe2}), 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

endmodule
